mips_fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the MIPS core, replacing direct single-cycle instruction feed.
- Owns the PC and issues in-order fetch requests to instruction memory over a valid/ready channel; the memory may answer with variable latency.
- Buffers responses in a DEPTH-entry queue.
- Presents the head instruction to decode with the standard MIPS fields pre-extracted.
- Supports redirect (jump/branch) with flush and discard of in-flight responses.

---
 rtl/mips_fetch_queue.sv | 118 +++++++++++
 tb/tb_mips_fetch_queue.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_queue.sv
// Instruction fetch front end: owns the PC, issues in-order fetches under a credit
// limit, buffers responses in a DEPTH-entry queue and pre-decodes the head for decode.
module mips_fetch_queue #(
   parameter int                ADDR_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     imem_req_valid,
   input  logic                     imem_req_ready,
   output logic [ADDR_W-1:0]        imem_req_addr,
   input  logic                     imem_resp_valid,
   input  logic [31:0]              imem_resp_data,
   input  logic                     redirect_valid,
   input  logic [ADDR_W-1:0]        redirect_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ADDR_W-1:0]        out_pc,
   output logic [31:0]              out_instr,
   output logic [5:0]               out_opcode,
   output logic [4:0]               out_rs,
   output logic [4:0]               out_rt,
   output logic [4:0]               out_rd,
   output logic [4:0]               out_shamt,
   output logic [5:0]               out_funct,
   output logic [15:0]              out_imm,
   output logic [ADDR_W-1:0]        out_simm,
   output logic [ADDR_W-1:0]        out_jtarget,
   output logic [$clog2(DEPTH):0]   out_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   // Outstanding may exceed DEPTH: stale fetches still in flight after a redirect
   // do not hold credits, so leave headroom above the live limit.
   localparam int OW = CW + 2;
   localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] JMASK  = ADDR_W'(28'hFFF_FFFF);
   localparam logic [CW-1:0]     FULL   = CW'(DEPTH);

   logic [ADDR_W-1:0] pc, resp_pc;
   logic [ADDR_W-1:0] q_pc    [DEPTH];
   logic [31:0]       q_instr [DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic [OW-1:0]     outstanding, drop, out_n;
   logic [OW:0]       inflight;
   logic              hs, push, pop;
   logic [ADDR_W-1:0] npc;

   assign inflight       = (OW+1)'(count) + (OW+1)'(outstanding) - (OW+1)'(drop);
   assign imem_req_valid = rst && (inflight < (OW+1)'(DEPTH));
   assign imem_req_addr  = pc;
   assign hs             = imem_req_valid && imem_req_ready;
   assign out_n          = outstanding + OW'(hs) - OW'(imem_resp_valid);

   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready && !redirect_valid;
   assign push      = rst && imem_resp_valid && !redirect_valid && (drop == '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc          <= RESET_PC;
         resp_pc     <= RESET_PC;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         outstanding <= '0;
         drop        <= '0;
      end else begin
         outstanding <= out_n;
         if (redirect_valid) begin
            // A response landing this cycle is already excluded from out_n.
            pc      <= redirect_pc;
            resp_pc <= redirect_pc;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            drop    <= out_n;
         end else begin
            if (hs)
               pc <= pc + PC_INC;
            if (imem_resp_valid && drop != '0)
               drop <= drop - OW'(1);
            if (push) begin
               wr_ptr  <= wr_ptr + PW'(1);
               resp_pc <= resp_pc + PC_INC;
            end
            if (pop)
               rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (push && !pop)
               assert (count != FULL);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[wr_ptr]    <= resp_pc;
         q_instr[wr_ptr] <= imem_resp_data;
      end
   end

   assign out_count   = count;
   assign out_pc      = out_valid ? q_pc[rd_ptr]    : '0;
   assign out_instr   = out_valid ? q_instr[rd_ptr] : '0;
   assign out_opcode  = out_instr[31:26];
   assign out_rs      = out_instr[25:21];
   assign out_rt      = out_instr[20:16];
   assign out_rd      = out_instr[15:11];
   assign out_shamt   = out_instr[10:6];
   assign out_funct   = out_instr[5:0];
   assign out_imm     = out_instr[15:0];
   assign out_simm    = {{(ADDR_W-16){out_instr[15]}}, out_instr[15:0]};
   assign npc         = out_pc + PC_INC;
   assign out_jtarget = (npc & ~JMASK) | ADDR_W'({out_instr[25:0], 2'b00});
endmodule

// File: tb/tb_mips_fetch_queue.sv
// Bench for mips_fetch_queue: directed scenarios then random traffic, all checked
// every cycle against a queue-based model of fetches, staleness and the head entry.
module tb_mips_fetch_queue;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid, out_ready;
   logic [31:0] out_pc, out_instr, out_simm, out_jtarget;
   logic [5:0]  out_opcode, out_funct;
   logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
   logic [15:0] out_imm;
   logic [2:0]  out_count;

   mips_fetch_queue #(.ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instr(out_instr),
      .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
      .out_shamt(out_shamt), .out_funct(out_funct), .out_imm(out_imm),
      .out_simm(out_simm), .out_jtarget(out_jtarget), .out_count(out_count)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;

   ent_t        mq[$];    // expected queue contents
   bit          ost[$];   // outstanding fetches, 1 = stale
   logic [31:0] pa[$];    // memory: pending addresses
   int          pd[$];    // memory: due cycle
   logic [31:0] mpc;
   int          cycle = 0, lat = 1, total = 0, bad = 0, n_hs = 0;
   bit          chk_en = 1'b1, prev_rst = 1'b0;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      if (a == 32'h0)          return 32'h8C22_0004;
      if (a == 32'h1000_0000)  return 32'h0800_0100;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      bit rsp, s, hs, ev, erv;
      logic [31:0] raddr, hpc, hin, npc;
      int live;
      if (rst && !prev_rst) begin pa.delete(); pd.delete(); end
      prev_rst = rst;
      rsp = (pa.size() > 0) && (pd[0] <= cycle);
      raddr = rsp ? pa[0] : 32'h0;
      imem_resp_valid = rsp;
      imem_resp_data  = rsp ? memfn(raddr) : $urandom;
      #1;
      ev  = (mq.size() > 0);
      hpc = ev ? mq[0].pc : 32'h0;
      hin = ev ? mq[0].instr : 32'h0;
      live = 0;
      foreach (ost[i]) if (!ost[i]) live++;
      erv = rst && (mq.size() + live < DEPTH);
      npc = hpc + 32'd4;
      if (chk_en) begin
         chk("out_valid", out_valid, ev);
         chk("out_count", out_count, mq.size());
         chk("out_pc", out_pc, hpc);
         chk("out_instr", out_instr, hin);
         chk("opcode", out_opcode, hin[31:26]);
         chk("rs", out_rs, hin[25:21]);
         chk("rt", out_rt, hin[20:16]);
         chk("rd", out_rd, hin[15:11]);
         chk("shamt", out_shamt, hin[10:6]);
         chk("funct", out_funct, hin[5:0]);
         chk("imm", out_imm, hin[15:0]);
         chk("simm", out_simm, {{16{hin[15]}}, hin[15:0]});
         chk("jtarget", out_jtarget, {npc[31:28], hin[25:0], 2'b00});
         chk("req_valid", imem_req_valid, erv);
         if (erv) chk("req_addr", imem_req_addr, mpc);
      end
      if (imem_req_valid && imem_req_ready) n_hs++;
      hs = erv && imem_req_ready;
      if (rsp) begin void'(pa.pop_front()); void'(pd.pop_front()); end
      if (!rst) begin
         mq.delete(); ost.delete(); mpc = 32'h0;
      end else begin
         s = 1'b0;
         if (rsp) s = ost.pop_front();
         if (hs) begin ost.push_back(1'b0); pa.push_back(mpc); pd.push_back(cycle + lat); end
         if (redirect_valid) begin
            foreach (ost[i]) ost[i] = 1'b1;
            mq.delete();
            mpc = redirect_pc;
         end else begin
            if (ev && out_ready) void'(mq.pop_front());
            if (rsp && !s) mq.push_back({raddr, memfn(raddr)});
            if (hs) mpc = mpc + 32'd4;
         end
      end
      cycle++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      repeat (n) cyc();
      rst = 1'b1;
      #1;
   endtask

   task automatic wait_valid(input string tag);
      int i;
      for (i = 0; i < 30 && !out_valid; i++) cyc();
      chk(tag, out_valid, 1'b1);
   endtask

   initial begin
      bit found;
      rst = 1'b0; out_ready = 1'b0; imem_req_ready = 1'b1;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      imem_resp_valid = 1'b0; imem_resp_data = 32'h0;

      // reset and first fetches, 1-cycle memory
      chk_en = 1'b0; cyc(); chk_en = 1'b1;
      do_reset(1);
      chk("rst_count", out_count, 0);
      chk("rst_valid", out_valid, 0);
      chk("first_addr", imem_req_addr, 32'h0);
      cyc();
      chk("addr4", imem_req_addr, 32'h4);
      chk("no_bypass", out_valid, 0);
      cyc();
      chk("addr8", imem_req_addr, 32'h8);
      chk("lw_valid", out_valid, 1);
      chk("lw_opcode", out_opcode, 6'h23);
      chk("lw_rs", out_rs, 5'd1);
      chk("lw_rt", out_rt, 5'd2);
      chk("lw_simm", out_simm, 32'h4);
      cyc();
      chk("addrC", imem_req_addr, 32'hC);

      // backpressure
      do_reset(2);
      n_hs = 0;
      repeat (8) cyc();
      chk("bp_hs", n_hs, 4);
      chk("bp_reqv", imem_req_valid, 0);
      chk("bp_count", out_count, 4);
      n_hs = 0;
      out_ready = 1'b1; cyc(); out_ready = 1'b0;
      repeat (4) cyc();
      chk("bp_one_more", n_hs, 1);

      // redirect with three in flight
      do_reset(2);
      lat = 3;
      repeat (3) cyc();
      redirect_valid = 1'b1; redirect_pc = 32'h400; cyc(); redirect_valid = 1'b0;
      wait_valid("redir_wait");
      chk("redir_pc", out_pc, 32'h400);
      chk("redir_instr", out_instr, memfn(32'h400));

      // redirect coinciding with pop and response
      lat = 1; out_ready = 1'b1; found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (out_valid && pa.size() > 0 && pd[0] <= cycle) found = 1'b1;
         else cyc();
      end
      chk("same_setup", found, 1'b1);
      redirect_valid = 1'b1; redirect_pc = 32'h2000; cyc(); redirect_valid = 1'b0;
      chk("same_count", out_count, 0);
      chk("same_valid", out_valid, 0);
      out_ready = 1'b0;
      wait_valid("same_wait");
      chk("same_pc", out_pc, 32'h2000);

      // jump target
      redirect_valid = 1'b1; redirect_pc = 32'h1000_0000; cyc(); redirect_valid = 1'b0;
      wait_valid("jt_wait");
      chk("jt_instr", out_instr, 32'h0800_0100);
      chk("jt_target", out_jtarget, 32'h1000_0400);

      // mid-operation reset with responses still in flight
      lat = 3;
      for (int i = 0; i < 20 && out_count != 3'd4; i++) cyc();
      chk("mid_full", out_count, 4);
      out_ready = 1'b1; cyc(); cyc(); out_ready = 1'b0; cyc();
      chk("mid_inflight", pa.size(), 2);
      do_reset(4);
      chk("mid_count", out_count, 0);
      chk("mid_valid", out_valid, 0);
      chk("mid_addr", imem_req_addr, 32'h0);
      chk("mid_reqv", imem_req_valid, 1);
      lat = 1;
      wait_valid("mid_wait");
      chk("mid_pc", out_pc, 32'h0);

      // random traffic
      for (int k = 0; k < 800; k++) begin
         out_ready      = ($urandom_range(0, 3) != 0);
         imem_req_ready = ($urandom_range(0, 3) != 0);
         lat            = $urandom_range(1, 4);
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
         rst            = ($urandom_range(0, 99) != 0);
         cyc();
      end
      rst = 1'b1; redirect_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
